sd_hit_logger: RTL

SD_HIT_LOGGER -- requirements
Module: sd_hit_logger

---
 rtl/sd_pkg.sv | 14 +
 rtl/sd_ts_fifo.sv | 75 +++++++
 rtl/sd_hit_logger.sv | 55 +++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared defaults and occupancy-state encoding for the hit logger.
package sd_pkg;

  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam int unsigned DEFAULT_TS_W  = 8;
  localparam int unsigned DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/sd_ts_fifo.sv
// Timestamp FIFO with registered head; push and pop may coincide in any state.
module sd_ts_fifo
  import sd_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned W     = DEFAULT_TS_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         valid,
  output logic [W-1:0] rdata,
  output logic         full_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] count, count_n;
  occ_state_e    state, state_n;
  logic          do_push, do_pop;

  assign full_c  = (state == OCC_FULL);
  assign do_pop  = pop && valid && !flush;
  assign do_push = push && !flush && (!full_c || do_pop);
  assign rptr_n  = do_pop ? rptr + AW'(1) : rptr;

  // Occupancy next-state
  always_comb begin
    count_n = count;
    state_n = state;
    if (flush)                  count_n = '0;
    else if (do_push && !do_pop) count_n = count + CW'(1);
    else if (do_pop && !do_push) count_n = count - CW'(1);
    if (count_n == '0)               state_n = OCC_EMPTY;
    else if (count_n == CW'(DEPTH))  state_n = OCC_FULL;
    else                             state_n = OCC_PARTIAL;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Head register forwards the incoming word when it lands in the next head slot
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OCC_EMPTY;
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      valid <= (state_n != OCC_EMPTY);
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        rdata <= '0;
      end else begin
        if (do_push) wptr <= wptr + AW'(1);
        rptr <= rptr_n;
        if (state_n != OCC_EMPTY)
          rdata <= (do_push && (wptr == rptr_n)) ? wdata : mem[rptr_n];
      end
    end
  end

endmodule

// File: rtl/sd_hit_logger.sv
// Timestamps qualified detector hits into a FIFO; counts hits and flags drops.
module sd_hit_logger
  import sd_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned TS_W  = DEFAULT_TS_W,
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic             en,
  input  logic             clear,
  input  logic             ts_ready,
  output logic             ts_valid,
  output logic [TS_W-1:0]  ts_data,
  output logic [CNT_W-1:0] hit_count,
  output logic             overflow
);

  logic [TS_W-1:0] ts;
  logic            qhit, pop, full_c;

  assign qhit = hit && en && !clear;
  assign pop  = ts_valid && ts_ready && !clear;

  sd_ts_fifo #(.DEPTH(DEPTH), .W(TS_W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush  (clear),
    .push   (qhit),
    .pop    (pop),
    .wdata  (ts),
    .valid  (ts_valid),
    .rdata  (ts_data),
    .full_c (full_c)
  );

  // Free-running timestamp; clear does not touch it
  always_ff @(posedge clk) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (qhit && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
      if (qhit && full_c && !pop)    overflow  <= 1'b1;
    end
  end

endmodule
